// File: rtl/sipo_frame_rx_pkg.sv
// Shared definitions for the framed serial receiver.
// State encoding and default width used by RTL and benches.
package sipo_frame_rx_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        DATA      = 2'd1,
        STOP      = 2'd2,
        WAIT_HIGH = 2'd3
    } rx_state_t;

    localparam int DEF_WIDTH = 4;

endpackage

// File: rtl/sipo_out_buf.sv
// Single-entry valid/ready output register.
// A load in the same cycle as a drain keeps the entry valid.
module sipo_out_buf
    import sipo_frame_rx_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    input  logic             ready,
    output logic [WIDTH-1:0] dout,
    output logic             valid,
    output logic             full,
    output logic             drain
);

    assign full  = valid;
    assign drain = valid & ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dout  <= '0;
            valid <= 1'b0;
        end else if (load) begin
            dout  <= din;
            valid <= 1'b1;
        end else if (drain) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/sipo_frame_rx.sv
// Framed serial-in, parallel-out receiver.
// Start bit, WIDTH data bits, stop bit; sampled on sin_en strobes.
module sipo_frame_rx
    import sipo_frame_rx_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sin,
    input  logic             sin_en,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             frame_err,
    output logic             overrun
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    rx_state_t        state, state_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic [WIDTH-1:0] sreg, sreg_n, shifted;
    logic             load, ferr_n, ovr_n;
    logic             full, drain;

    always_comb begin
        if (LSB_FIRST) shifted = {sin, sreg[WIDTH-1:1]};
        else           shifted = {sreg[WIDTH-2:0], sin};
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        sreg_n  = sreg;
        load    = 1'b0;
        ferr_n  = 1'b0;
        ovr_n   = 1'b0;
        if (sin_en) begin
            unique case (state)
                IDLE: begin
                    if (!sin) begin
                        state_n = DATA;
                        cnt_n   = '0;
                    end
                end
                DATA: begin
                    sreg_n = shifted;
                    cnt_n  = cnt + 1'b1;
                    if (cnt == LAST) state_n = STOP;
                end
                STOP: begin
                    if (sin) begin
                        state_n = IDLE;
                        if (!full || drain) load  = 1'b1;
                        else                ovr_n = 1'b1;
                    end else begin
                        state_n = WAIT_HIGH;
                        ferr_n  = 1'b1;
                    end
                end
                WAIT_HIGH: begin
                    // a low line here is still the broken frame, not a start
                    if (sin) state_n = IDLE;
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            sreg      <= '0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            sreg      <= sreg_n;
            frame_err <= ferr_n;
            overrun   <= ovr_n;
        end
    end

    sipo_out_buf #(.WIDTH(WIDTH)) u_buf (
        .clk   (clk),
        .reset (reset),
        .load  (load),
        .din   (sreg),
        .ready (dout_ready),
        .dout  (dout),
        .valid (dout_valid),
        .full  (full),
        .drain (drain)
    );

endmodule

// File: tb/tb_sipo_frame_rx.sv
// Scoreboard bench for sipo_frame_rx, LSB-first and MSB-first
// instances driven by the same serial line.
module tb_sipo_frame_rx;

    logic       clk = 1'b0;
    logic       rst_n, sin, sin_en, ready;
    logic [3:0] dout_l, dout_m;
    logic       val_l, val_m, fe_l, fe_m, ov_l, ov_m;

    int n_chk  = 0;
    int n_fail = 0;
    int nfe_l = 0, nfe_m = 0, nov_l = 0, nov_m = 0;

    logic [3:0] ql[$];
    logic [3:0] qm[$];

    always #5 clk = ~clk;

    sipo_frame_rx #(.WIDTH(4), .LSB_FIRST(1'b1)) u_lsb (
        .clk(clk), .reset(rst_n), .sin(sin), .sin_en(sin_en),
        .dout(dout_l), .dout_valid(val_l), .dout_ready(ready),
        .frame_err(fe_l), .overrun(ov_l)
    );

    sipo_frame_rx #(.WIDTH(4), .LSB_FIRST(1'b0)) u_msb (
        .clk(clk), .reset(rst_n), .sin(sin), .sin_en(sin_en),
        .dout(dout_m), .dout_valid(val_m), .dout_ready(ready),
        .frame_err(fe_m), .overrun(ov_m)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && val_l && ready) begin
            if (ql.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL lsb_sb: unexpected word %0h, expected none",
                         dout_l);
            end else begin
                chk("lsb_sb", 32'(dout_l), 32'(ql.pop_front()));
            end
        end
        if (rst_n && val_m && ready) begin
            if (qm.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL msb_sb: unexpected word %0h, expected none",
                         dout_m);
            end else begin
                chk("msb_sb", 32'(dout_m), 32'(qm.pop_front()));
            end
        end
        if (fe_l) nfe_l++;
        if (fe_m) nfe_m++;
        if (ov_l) nov_l++;
        if (ov_m) nov_m++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bitx(input logic b, input int per);
        for (int i = 0; i < per - 1; i++) begin
            sin_en = 1'b0;
            tick();
        end
        sin    = b;
        sin_en = 1'b1;
        tick();
        sin_en = 1'b0;
    endtask

    task automatic idle(input int n);
        sin    = 1'b1;
        sin_en = 1'b1;
        repeat (n) tick();
        sin_en = 1'b0;
    endtask

    // seq[i] is the i-th data bit on the line
    task automatic send(input logic [3:0] seq, input logic stopb,
                        input int per);
        bitx(1'b0, per);
        for (int i = 0; i < 4; i++) bitx(seq[i], per);
        bitx(stopb, per);
    endtask

    initial begin
        rst_n  = 1'b0;
        sin    = 1'b1;
        sin_en = 1'b0;
        ready  = 1'b1;
        repeat (3) tick();
        chk("rst_valid", 32'(val_l | val_m), 0);
        chk("rst_dout", 32'({dout_l, dout_m}), 0);
        rst_n = 1'b1;
        idle(5);
        chk("idle_outs", 32'({val_l, val_m, fe_l, fe_m, ov_l, ov_m}), 0);
        chk("idle_dout", 32'({dout_l, dout_m}), 0);

        // 0,1,0,1 on the line: A LSB-first, 5 MSB-first
        ql.push_back(4'hA); qm.push_back(4'h5);
        send(4'b1010, 1'b1, 1);
        chk("lat_valid", 32'({val_l, val_m}), 32'b11);
        chk("lat_dout_l", 32'(dout_l), 32'hA);
        chk("lat_dout_m", 32'(dout_m), 32'h5);
        tick();
        chk("valid_clear", 32'({val_l, val_m}), 0);

        // back-to-back frames
        ql.push_back(4'h6); qm.push_back(4'h6);
        send(4'b0110, 1'b1, 1);
        ql.push_back(4'h3); qm.push_back(4'hC);
        send(4'b0011, 1'b1, 1);
        ql.push_back(4'h1); qm.push_back(4'h8);
        send(4'b0001, 1'b1, 1);

        // strobe every third cycle
        ql.push_back(4'hA); qm.push_back(4'h5);
        send(4'b1010, 1'b1, 3);
        idle(2);

        // overrun: second word dropped while buffer is held
        ready = 1'b0;
        ql.push_back(4'h3); qm.push_back(4'hC);
        send(4'b0011, 1'b1, 1);
        send(4'b1100, 1'b1, 1);
        idle(3);
        chk("ovr_dout_l", 32'(dout_l), 32'h3);
        chk("ovr_dout_m", 32'(dout_m), 32'hC);
        chk("ovr_cnt_l", 32'(nov_l), 1);
        chk("ovr_cnt_m", 32'(nov_m), 1);
        ready = 1'b1;
        tick();
        tick();
        chk("ovr_drained", 32'({val_l, val_m}), 0);

        // framing error, low strobes ignored until line returns high
        send(4'b1111, 1'b0, 1);
        bitx(1'b0, 1);
        bitx(1'b0, 1);
        bitx(1'b1, 1);
        idle(2);
        chk("ferr_cnt_l", 32'(nfe_l), 1);
        chk("ferr_cnt_m", 32'(nfe_m), 1);
        ql.push_back(4'h6); qm.push_back(4'h6);
        send(4'b0110, 1'b1, 1);
        idle(2);

        // reset mid-frame with a word buffered
        ready = 1'b0;
        send(4'b0101, 1'b1, 1);
        bitx(1'b0, 1);
        bitx(1'b1, 1);
        bitx(1'b1, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'({val_l, val_m}), 0);
        chk("async_rst_dout", 32'({dout_l, dout_m}), 0);
        tick();
        rst_n = 1'b1;
        ready = 1'b1;
        tick();
        ql.push_back(4'h9); qm.push_back(4'h9);
        send(4'b1001, 1'b1, 1);
        chk("post_rst_dout_l", 32'(dout_l), 32'h9);
        idle(4);

        chk("sb_empty_l", 32'(ql.size()), 0);
        chk("sb_empty_m", 32'(qm.size()), 0);
        chk("final_fe", 32'(nfe_l + nfe_m), 2);
        chk("final_ov", 32'(nov_l + nov_m), 2);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
